// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: funct3 encodings, FSM states,
// access-size masks and small helpers for alignment and store lane replication.
package mem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_SD  = 3'b011;

   localparam logic [7:0] SIZE_MASK_B = 8'h01;
   localparam logic [7:0] SIZE_MASK_H = 8'h03;
   localparam logic [7:0] SIZE_MASK_W = 8'h0F;
   localparam logic [7:0] SIZE_MASK_D = 8'hFF;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   // Access size comes from funct3[1:0] for both loads and stores.
   function automatic logic [7:0] size_mask(input logic [1:0] sz);
      case (sz)
         2'd0:    size_mask = SIZE_MASK_B;
         2'd1:    size_mask = SIZE_MASK_H;
         2'd2:    size_mask = SIZE_MASK_W;
         default: size_mask = SIZE_MASK_D;
      endcase
   endfunction

   function automatic logic is_aligned(input logic [2:0] off, input logic [1:0] sz);
      case (sz)
         2'd0:    is_aligned = 1'b1;
         2'd1:    is_aligned = (off[0] == 1'b0);
         2'd2:    is_aligned = (off[1:0] == 2'b00);
         default: is_aligned = (off == 3'b000);
      endcase
   endfunction

   function automatic logic [63:0] replicate_lanes(input logic [63:0] d, input logic [1:0] sz);
      case (sz)
         2'd0:    replicate_lanes = {8{d[7:0]}};
         2'd1:    replicate_lanes = {4{d[15:0]}};
         2'd2:    replicate_lanes = {2{d[31:0]}};
         default: replicate_lanes = d;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load lane extraction: shifts the addressed bytes of an aligned doubleword down
// to bit 0 and sign- or zero-extends them according to funct3.
module load_align
   import mem_pkg::*;
(
   input  logic [63:0] rdata,
   input  logic [2:0]  offset,
   input  logic [2:0]  funct3,
   output logic [63:0] value
);

   logic [63:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (funct3)
         F3_LB:   value = {{56{shifted[7]}},  shifted[7:0]};
         F3_LH:   value = {{48{shifted[15]}}, shifted[15:0]};
         F3_LW:   value = {{32{shifted[31]}}, shifted[31:0]};
         F3_LBU:  value = {56'd0, shifted[7:0]};
         F3_LHU:  value = {48'd0, shifted[15:0]};
         F3_LWU:  value = {32'd0, shifted[31:0]};
         default: value = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// RV64 memory-access stage: issues dmem requests, resolves branches and
// produces the registered writeback bundle.
//
// state | meaning
// IDLE  | accepting a new instruction from execute
// WAIT  | dmem request outstanding, upstream stalled until ack or timeout
module mem_stage
   import mem_pkg::*;
#(
   parameter int XLEN    = 64,
   parameter int TIMEOUT = 255
) (
   input  logic            CLK,
   input  logic            RST_N,
   input  logic [XLEN-1:0] res_i,
   input  logic            alu_write_back_en_i,
   input  logic [4:0]      rd_i,
   input  logic            load_flag_i,
   input  logic            mem_en_i,
   input  logic            branch_flag_i,
   input  logic [XLEN-1:0] branch_offset_i,
   input  logic [XLEN-1:0] PC_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] store_data_i,
   output logic            dmem_req,
   output logic            dmem_we,
   output logic [XLEN-1:0] dmem_addr,
   output logic [XLEN-1:0] dmem_wdata,
   output logic [7:0]      dmem_wstrb,
   input  logic            dmem_ack,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            stall,
   output logic            take_branch,
   output logic [XLEN-1:0] branch_target,
   output logic            wb_en,
   output logic [4:0]      wb_rd,
   output logic [XLEN-1:0] wb_data,
   output logic            mem_err
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  to_cnt;
   logic [4:0]  rd_q;
   logic [2:0]  f3_q;
   logic        ld_q;
   logic [2:0]  off_q;
   logic [63:0] ld_value;
   logic        in_aligned;

   assign in_aligned = is_aligned(res_i[2:0], funct3_i[1:0]);

   load_align u_load_align (
      .rdata  (dmem_rdata),
      .offset (off_q),
      .funct3 (f3_q),
      .value  (ld_value)
   );

   // Branches take priority over a (malformed) simultaneous mem_en.
   always_comb begin
      stall = 1'b0;
      if (state == WAIT)
         stall = !dmem_ack;
      else if (!take_branch && !branch_flag_i && mem_en_i && in_aligned)
         stall = 1'b1;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state         <= IDLE;
         to_cnt        <= '0;
         rd_q          <= '0;
         f3_q          <= '0;
         ld_q          <= 1'b0;
         off_q         <= '0;
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_wstrb    <= '0;
         take_branch   <= 1'b0;
         branch_target <= '0;
         wb_en         <= 1'b0;
         wb_rd         <= '0;
         wb_data       <= '0;
         mem_err       <= 1'b0;
      end else begin
         wb_en       <= 1'b0;
         take_branch <= 1'b0;
         mem_err     <= 1'b0;
         case (state)
            IDLE: begin
               if (!take_branch) begin
                  if (branch_flag_i) begin
                     take_branch   <= res_i[0];
                     branch_target <= PC_i + branch_offset_i;
                  end else if (mem_en_i) begin
                     if (in_aligned) begin
                        rd_q       <= rd_i;
                        f3_q       <= funct3_i;
                        ld_q       <= load_flag_i;
                        off_q      <= res_i[2:0];
                        dmem_req   <= 1'b1;
                        dmem_we    <= !load_flag_i;
                        dmem_addr  <= {res_i[63:3], 3'b000};
                        dmem_wdata <= replicate_lanes(store_data_i, funct3_i[1:0]);
                        dmem_wstrb <= size_mask(funct3_i[1:0]) << res_i[2:0];
                        to_cnt     <= '0;
                        state      <= WAIT;
                     end else begin
                        mem_err <= 1'b1;
                     end
                  end else begin
                     wb_en   <= alu_write_back_en_i && (rd_i != 5'd0);
                     wb_rd   <= rd_i;
                     wb_data <= res_i;
                  end
               end
            end
            WAIT: begin
               if (dmem_ack) begin
                  dmem_req <= 1'b0;
                  to_cnt   <= '0;
                  state    <= IDLE;
                  if (ld_q) begin
                     wb_en   <= (rd_q != 5'd0);
                     wb_rd   <= rd_q;
                     wb_data <= ld_value;
                  end
               end else if (to_cnt == TO_LAST) begin
                  dmem_req <= 1'b0;
                  mem_err  <= 1'b1;
                  to_cnt   <= '0;
                  state    <= IDLE;
               end else begin
                  to_cnt <= to_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: writebacks are scoreboarded through a queue,
// each scenario task checks handshake, stall, branch and error behaviour inline.
module tb_mem_stage;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic [63:0] res_i;
   logic        alu_write_back_en_i;
   logic [4:0]  rd_i;
   logic        load_flag_i;
   logic        mem_en_i;
   logic        branch_flag_i;
   logic [63:0] branch_offset_i;
   logic [63:0] PC_i;
   logic [2:0]  funct3_i;
   logic [63:0] store_data_i;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_wstrb;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;
   logic        stall;
   logic        take_branch;
   logic [63:0] branch_target;
   logic        wb_en;
   logic [4:0]  wb_rd;
   logic [63:0] wb_data;
   logic        mem_err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } wb_t;

   wb_t exp_q[$];

   mem_stage #(.XLEN(64), .TIMEOUT(4)) dut (
      .CLK                 (CLK),
      .RST_N               (RST_N),
      .res_i               (res_i),
      .alu_write_back_en_i (alu_write_back_en_i),
      .rd_i                (rd_i),
      .load_flag_i         (load_flag_i),
      .mem_en_i            (mem_en_i),
      .branch_flag_i       (branch_flag_i),
      .branch_offset_i     (branch_offset_i),
      .PC_i                (PC_i),
      .funct3_i            (funct3_i),
      .store_data_i        (store_data_i),
      .dmem_req            (dmem_req),
      .dmem_we             (dmem_we),
      .dmem_addr           (dmem_addr),
      .dmem_wdata          (dmem_wdata),
      .dmem_wstrb          (dmem_wstrb),
      .dmem_ack            (dmem_ack),
      .dmem_rdata          (dmem_rdata),
      .stall               (stall),
      .take_branch         (take_branch),
      .branch_target       (branch_target),
      .wb_en               (wb_en),
      .wb_rd               (wb_rd),
      .wb_data             (wb_data),
      .mem_err             (mem_err)
   );

   always #5 CLK = ~CLK;

   // Writeback scoreboard: every wb_en pulse must match the oldest expectation.
   always @(negedge CLK) begin
      wb_t e;
      if (RST_N === 1'b1 && wb_en === 1'b1) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wb_unexpected got rd=%0d data=%h expected no writeback", wb_rd, wb_data);
         end else begin
            e = exp_q.pop_front();
            if (wb_rd !== e.rd || wb_data !== e.data) begin
               errors++;
               $display("FAIL wb_data got rd=%0d data=%h expected rd=%0d data=%h",
                        wb_rd, wb_data, e.rd, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive_idle();
      res_i               = '0;
      alu_write_back_en_i = 1'b0;
      rd_i                = '0;
      load_flag_i         = 1'b0;
      mem_en_i            = 1'b0;
      branch_flag_i       = 1'b0;
      branch_offset_i     = '0;
      PC_i                = '0;
      funct3_i            = '0;
      store_data_i        = '0;
   endtask

   task automatic push_wb(input logic [4:0] rd, input logic [63:0] data);
      wb_t e;
      e.rd   = rd;
      e.data = data;
      exp_q.push_back(e);
   endtask

   task automatic test_reset();
      drive_idle();
      dmem_ack   = 1'b0;
      dmem_rdata = '0;
      RST_N      = 1'b1;
      #2 RST_N   = 1'b0;
      repeat (3) step();
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, take_branch, branch_target,
           wb_en, wb_rd, wb_data, mem_err, stall} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got req=%b we=%b addr=%h wstrb=%h tb=%b wb_en=%b wb_data=%h err=%b stall=%b expected all 0",
                  dmem_req, dmem_we, dmem_addr, dmem_wstrb, take_branch, wb_en, wb_data, mem_err, stall);
      end
      RST_N = 1'b1;
      step();
   endtask

   task automatic test_alu();
      res_i = 64'h1234; alu_write_back_en_i = 1'b1; rd_i = 5'd5;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL alu_stall got %b expected 0", stall);
      end
      push_wb(5'd5, 64'h1234);
      step();
      checks++;
      if (wb_en !== 1'b1) begin
         errors++; $display("FAIL alu_wb_en got %b expected 1", wb_en);
      end
      rd_i = 5'd0;
      step();
      checks++;
      if (wb_en !== 1'b0) begin
         errors++; $display("FAIL alu_rd0 got wb_en=%b expected 0", wb_en);
      end
      drive_idle();
      step();
   endtask

   task automatic test_load(input logic [2:0] f3, input logic [63:0] expv, input string name);
      int stall_cnt = 0;
      res_i = 64'h1004; mem_en_i = 1'b1; load_flag_i = 1'b1; funct3_i = f3; rd_i = 5'd7;
      #1;
      if (stall === 1'b1) stall_cnt++;
      step();
      drive_idle();
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 64'h1000 || dmem_we !== 1'b0) begin
         errors++;
         $display("FAIL %s_req got req=%b addr=%h we=%b expected req=1 addr=1000 we=0",
                  name, dmem_req, dmem_addr, dmem_we);
      end
      for (int i = 0; i < 3; i++) begin
         if (stall === 1'b1) stall_cnt++;
         step();
      end
      dmem_ack   = 1'b1;
      dmem_rdata = 64'h80000001_00000000;
      #1;
      if (stall === 1'b1) stall_cnt++;
      push_wb(5'd7, expv);
      step();
      dmem_ack = 1'b0;
      checks++;
      if (stall_cnt != 4) begin
         errors++; $display("FAIL %s_stall_cycles got %0d expected 4", name, stall_cnt);
      end
      checks++;
      if (dmem_req !== 1'b0 || wb_en !== 1'b1) begin
         errors++;
         $display("FAIL %s_complete got req=%b wb_en=%b expected req=0 wb_en=1", name, dmem_req, wb_en);
      end
      step();
   endtask

   task automatic test_store();
      res_i = 64'h2006; mem_en_i = 1'b1; load_flag_i = 1'b0; funct3_i = 3'b001;
      store_data_i = 64'hDEAD_BEEF_0000_1234; rd_i = 5'd9;
      step();
      drive_idle();
      checks++;
      if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 64'h2000 ||
          dmem_wstrb !== 8'hC0 || dmem_wdata !== 64'h1234123412341234) begin
         errors++;
         $display("FAIL sh_req got req=%b we=%b addr=%h wstrb=%h wdata=%h expected 1 1 2000 c0 1234123412341234",
                  dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata);
      end
      step();
      checks++;
      if (stall !== 1'b1 || dmem_wstrb !== 8'hC0) begin
         errors++;
         $display("FAIL sh_hold got stall=%b wstrb=%h expected stall=1 wstrb=c0", stall, dmem_wstrb);
      end
      dmem_ack = 1'b1;
      step();
      dmem_ack = 1'b0;
      checks++;
      if (dmem_req !== 1'b0 || wb_en !== 1'b0) begin
         errors++;
         $display("FAIL sh_done got req=%b wb_en=%b expected 0 0", dmem_req, wb_en);
      end
      step();
   endtask

   task automatic test_branch();
      branch_flag_i = 1'b1; res_i = 64'd1; PC_i = 64'h100; branch_offset_i = 64'h40;
      step();
      drive_idle();
      res_i = 64'h55; alu_write_back_en_i = 1'b1; rd_i = 5'd3;
      checks++;
      if (take_branch !== 1'b1 || branch_target !== 64'h140 || wb_en !== 1'b0) begin
         errors++;
         $display("FAIL br_taken got tb=%b target=%h wb_en=%b expected 1 140 0",
                  take_branch, branch_target, wb_en);
      end
      step();
      drive_idle();
      checks++;
      if (take_branch !== 1'b0 || wb_en !== 1'b0) begin
         errors++;
         $display("FAIL br_squash got tb=%b wb_en=%b expected 0 0", take_branch, wb_en);
      end
      branch_flag_i = 1'b1; res_i = 64'd0; PC_i = 64'h200; branch_offset_i = 64'h8;
      step();
      checks++;
      if (take_branch !== 1'b0) begin
         errors++; $display("FAIL br_not_taken got %b expected 0", take_branch);
      end
      res_i = 64'd1; PC_i = 64'hFFFF_FFFF_FFFF_FFF0; branch_offset_i = 64'h20;
      step();
      drive_idle();
      checks++;
      if (take_branch !== 1'b1 || branch_target !== 64'h10) begin
         errors++;
         $display("FAIL br_wrap got tb=%b target=%h expected 1 10", take_branch, branch_target);
      end
      step();
   endtask

   task automatic test_misaligned();
      res_i = 64'h1002; mem_en_i = 1'b1; load_flag_i = 1'b1; funct3_i = 3'b010; rd_i = 5'd4;
      #1;
      checks++;
      if (stall !== 1'b0) begin
         errors++; $display("FAIL mis_stall got %b expected 0", stall);
      end
      step();
      drive_idle();
      checks++;
      if (mem_err !== 1'b1 || dmem_req !== 1'b0 || wb_en !== 1'b0) begin
         errors++;
         $display("FAIL mis_err got err=%b req=%b wb_en=%b expected 1 0 0", mem_err, dmem_req, wb_en);
      end
      step();
      checks++;
      if (mem_err !== 1'b0 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL mis_pulse got err=%b req=%b expected 0 0", mem_err, dmem_req);
      end
   endtask

   task automatic test_timeout();
      res_i = 64'h3000; mem_en_i = 1'b1; load_flag_i = 1'b1; funct3_i = 3'b011; rd_i = 5'd6;
      step();
      drive_idle();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (stall !== 1'b1 || dmem_req !== 1'b1 || mem_err !== 1'b0) begin
            errors++;
            $display("FAIL to_wait%0d got stall=%b req=%b err=%b expected 1 1 0",
                     i, stall, dmem_req, mem_err);
         end
         step();
      end
      checks++;
      if (mem_err !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0 || wb_en !== 1'b0) begin
         errors++;
         $display("FAIL to_abort got err=%b req=%b stall=%b wb_en=%b expected 1 0 0 0",
                  mem_err, dmem_req, stall, wb_en);
      end
      step();
      checks++;
      if (mem_err !== 1'b0) begin
         errors++; $display("FAIL to_pulse got %b expected 0", mem_err);
      end
   endtask

   task automatic test_reset_mid_wait();
      res_i = 64'h5000; mem_en_i = 1'b1; load_flag_i = 1'b0; funct3_i = 3'b011;
      store_data_i = 64'hA5A5; rd_i = 5'd2;
      step();
      drive_idle();
      step();
      #2 RST_N = 1'b0;
      #1;
      checks++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, stall, wb_en, mem_err, take_branch} !== '0) begin
         errors++;
         $display("FAIL rst_mid got req=%b we=%b addr=%h wdata=%h wstrb=%h stall=%b wb_en=%b err=%b expected all 0",
                  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, stall, wb_en, mem_err);
      end
      step();
      RST_N = 1'b1;
      step();
      res_i = 64'hABCD; alu_write_back_en_i = 1'b1; rd_i = 5'd9;
      push_wb(5'd9, 64'hABCD);
      step();
      drive_idle();
      checks++;
      if (wb_en !== 1'b1 || dmem_req !== 1'b0) begin
         errors++;
         $display("FAIL rst_then_alu got wb_en=%b req=%b expected 1 0", wb_en, dmem_req);
      end
      dmem_ack = 1'b1; dmem_rdata = 64'hFFFF;
      step();
      dmem_ack = 1'b0;
      checks++;
      if (wb_en !== 1'b0 || dmem_req !== 1'b0 || stall !== 1'b0) begin
         errors++;
         $display("FAIL ack_in_idle got wb_en=%b req=%b stall=%b expected 0 0 0", wb_en, dmem_req, stall);
      end
   endtask

   task automatic test_back_to_back();
      res_i = 64'h11; alu_write_back_en_i = 1'b1; rd_i = 5'd1;
      push_wb(5'd1, 64'h11);
      step();
      res_i = 64'h22; rd_i = 5'd2;
      push_wb(5'd2, 64'h22);
      step();
      drive_idle();
      res_i = 64'h4003; mem_en_i = 1'b1; load_flag_i = 1'b1; funct3_i = 3'b000; rd_i = 5'd3;
      step();
      drive_idle();
      checks++;
      if (dmem_req !== 1'b1 || dmem_addr !== 64'h4000) begin
         errors++;
         $display("FAIL b2b_req got req=%b addr=%h expected 1 4000", dmem_req, dmem_addr);
      end
      dmem_ack = 1'b1; dmem_rdata = 64'h00000000_80000000;
      push_wb(5'd3, 64'hFFFF_FFFF_FFFF_FF80);
      step();
      dmem_ack = 1'b0;
      step();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL wb_pending got %0d outstanding expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_load(3'b010, 64'hFFFF_FFFF_8000_0001, "lw");
      test_load(3'b110, 64'h0000_0000_8000_0001, "lwu");
      test_store();
      test_branch();
      test_misaligned();
      test_timeout();
      test_reset_mid_wait();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the RV64 in-order pipeline. It sits directly downstream of the execute stage and consumes its registered result bundle.
- Issues loads and stores to the data-memory port using a req/ack handshake, and stalls upstream while an access is outstanding.
- Resolves branches from the execute-stage compare bit and returns the redirect/flush signal (take_branch) to the execute and fetch stages.
- Produces the registered writeback bundle for the register file.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported.
- TIMEOUT, 255, maximum number of cycles to wait for dmem_ack before aborting the access. Range 1..255.

Ports:
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- res_i  in  64  execute result: effective address for load/store, value for ALU ops, compare bit in [0] for branches
- alu_write_back_en_i  in  1  instruction writes rd
- rd_i  in  5  destination register
- load_flag_i  in  1  instruction is a load (a store when 0 and mem_en_i=1)
- mem_en_i  in  1  memory access requested
- branch_flag_i  in  1  instruction is a conditional branch
- branch_offset_i  in  64  sign-extended branch offset
- PC_i  in  64  PC of the instruction
- funct3_i  in  3  access size/sign for loads and stores
- store_data_i  in  64  rs2 value for stores
- dmem_req  out  1  access request
- dmem_we  out  1  1 = store
- dmem_addr  out  64  doubleword-aligned address ({res[63:3],3'b0})
- dmem_wdata  out  64  store data, lane-replicated
- dmem_wstrb  out  8  byte enables
- dmem_ack  in  1  access complete; rdata valid in the same cycle
- dmem_rdata  in  64  aligned doubleword read
- stall  out  1  combinational: upstream holds its registers
- take_branch  out  1  registered one-cycle redirect/flush pulse
- branch_target  out  64  PC_i + branch_offset_i, valid while take_branch=1
- wb_en  out  1  registered writeback enable
- wb_rd  out  5  registered writeback destination
- wb_data  out  64  registered writeback value
- mem_err  out  1  one-cycle pulse on a misaligned access or a timeout

Behaviour:
- Reset (asynchronous, RST_N=0): state=IDLE, timeout counter=0. All registered outputs (dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb, take_branch, branch_target, wb_en, wb_rd, wb_data, mem_err) go to 0. Reset asserted mid-access abandons the access; dmem_req drops immediately.
- Squash: in any cycle where take_branch=1, the inputs are ignored. No writeback, no access, no branch evaluation.
- States: IDLE and WAIT.
- IDLE, non-memory instruction: the next edge registers wb_en=alu_write_back_en_i & (rd_i!=0), wb_rd=rd_i, wb_data=res_i. Latency is 1 cycle.
- IDLE, branch (branch_flag_i=1): the next edge sets take_branch=res_i[0] and branch_target=PC_i+branch_offset_i (wraps mod 2^64), with wb_en=0.
- IDLE, mem_en_i with an aligned address:
  - stall=1 combinationally.
  - Next edge: latch rd, funct3, load flag and byte offset res_i[2:0]; drive dmem_req=1, dmem_we=!load_flag_i, address, wdata and wstrb; go to WAIT.
- Alignment rule: the address must be a multiple of the access size (1/2/4/8 bytes).
- IDLE, misaligned access: no request and no writeback. mem_err pulses on the next edge; stall stays 0.
- WAIT:
  - dmem_req and all request fields are held stable. Inputs are ignored.
  - stall=!dmem_ack.
  - On the edge where dmem_ack=1: dmem_req=0, go to IDLE. For loads, wb_en=(rd!=0) and wb_data=the extracted lane. Stores produce no writeback.
- Load extraction: the lane is selected by the byte offset, then extended by funct3:
  - 000 LB and 001 LH: sign-extend
  - 010 LW: sign-extend
  - 011 LD: full doubleword
  - 100 LBU, 101 LHU, 110 LWU: zero-extend
  - funct3=111 on a load is treated as LD.
- Store encoding: funct3 000 SB, 001 SH, 010 SW, 011 SD.
  - wdata replicates the low 1/2/4/8 bytes across all 64 bits.
  - wstrb is the size mask shifted left by the byte offset.
- Timeout: the counter increments each cycle in WAIT without an ack. When the count reaches TIMEOUT, dmem_req drops, mem_err pulses, there is no writeback, the state returns to IDLE, stall drops and the counter clears.
- dmem_ack received in IDLE is ignored.
- wb_en is 0 in every cycle that is not explicitly described above as producing a writeback.

Decomposition:
- Package mem_pkg holds: funct3 load/store localparams, the state encoding (IDLE/WAIT), and the size-mask constants.
- One natural sub-module, load_align: combinational lane select and sign/zero extension (rdata, offset, funct3 -> 64-bit value).

Test Plan:
- ALU op: res_i=0x1234, alu_write_back_en_i=1, rd_i=5 -> the next cycle shows wb_en=1, wb_rd=5, wb_data=0x1234, stall=0. With rd_i=0 -> wb_en=0.
- LW at res_i=0x1004; ack after 3 cycles with rdata=0x80000001_00000000 -> dmem_addr=0x1000, dmem_we=0; stall is high for 4 cycles; the cycle after ack shows wb_data=0xFFFFFFFF80000001. The same access as LWU gives 0x0000000080000001.
- SH at res_i=0x2006 with store_data_i=0x1234 -> dmem_addr=0x2000, dmem_wstrb=0xC0, dmem_wdata=0x1234123412341234, dmem_we=1; no writeback after ack.
- Branch: branch_flag_i=1, res_i=1, PC_i=0x100, branch_offset_i=0x40 -> take_branch=1 for exactly one cycle with branch_target=0x140; an ALU op presented in that cycle produces wb_en=0. With res_i=0 -> take_branch stays 0.
- LW at res_i=0x1002 -> mem_err pulses once; dmem_req never rises; wb_en=0.
- Error and reset cases:
  - TIMEOUT=4 with no ack -> mem_err pulses after 4 WAIT cycles, dmem_req drops, stall drops.
  - Assert RST_N=0 mid-WAIT -> all outputs 0 immediately; a subsequent ALU op completes normally.
